// File: rtl/tcm_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tcm_arbiter_pkg
// Shared TCM constants for the IFU/LSU tightly-coupled-memory arbiter.
//   TCM_XLEN : datapath width of the shared TCM
//   TCM_AW   : byte-address width of the shared TCM
//   TCM_MW   : byte-enable width (TCM_XLEN / 8)
// ---------------------------------------------------------------------------
package tcm_arbiter_pkg;

    localparam int unsigned TCM_XLEN = 32'd32;
    localparam int unsigned TCM_AW   = 32'd16;
    localparam int unsigned TCM_MW   = TCM_XLEN / 32'd8;

endpackage : tcm_arbiter_pkg

// File: rtl/tcm_arbiter.sv
// ---------------------------------------------------------------------------
// tcm_arbiter
// Two-master (IFU fetch, LSU load/store) arbiter in front of a single-port
// TCM with one cycle of read latency. Round-robin between the masters, one
// access per cycle, at most one response outstanding; a stalled response is
// parked in a hold register so the RAM output may change underneath it.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   ifu_cmd_valid/ready/addr        IFU read command
//   ifu_rsp_valid/ready/rdata       IFU response
//   lsu_cmd_valid/ready/read/addr/
//     wdata/wmask                   LSU load/store command
//   lsu_rsp_valid/ready/rdata       LSU response (rdata is 0 for stores)
//   ram_cs/we/addr/wem/din          RAM command (word address)
//   ram_dout                        RAM read data, valid the cycle after cs
// ---------------------------------------------------------------------------
module tcm_arbiter
    import tcm_arbiter_pkg::*;
#(
    parameter int unsigned AW   = TCM_AW,
    parameter int unsigned XLEN = TCM_XLEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_cmd_valid,
    output logic                ifu_cmd_ready,
    input  logic [AW-1:0]       ifu_cmd_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [XLEN-1:0]     ifu_rsp_rdata,
    input  logic                lsu_cmd_valid,
    output logic                lsu_cmd_ready,
    input  logic                lsu_cmd_read,
    input  logic [AW-1:0]       lsu_cmd_addr,
    input  logic [XLEN-1:0]     lsu_cmd_wdata,
    input  logic [XLEN/8-1:0]   lsu_cmd_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [XLEN-1:0]     lsu_rsp_rdata,
    output logic                ram_cs,
    output logic                ram_we,
    output logic [AW-3:0]       ram_addr,
    output logic [XLEN/8-1:0]   ram_wem,
    output logic [XLEN-1:0]     ram_din,
    input  logic [XLEN-1:0]     ram_dout
);

    localparam int unsigned MW = XLEN / 32'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RSP  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    state_e            state_r;
    owner_e            owner_r;
    logic              is_write_r;
    logic [XLEN-1:0]   hold_r;
    logic              prio_lsu_r;   // 1: LSU wins a tie (IFU was granted last)

    logic              rsp_busy_s;
    logic              rsp_ready_s;
    logic              rsp_hs_s;
    logic              can_accept_s;
    logic              sel_lsu_s;
    logic              grant_s;
    logic              write_s;
    logic [XLEN-1:0]   rsp_data_s;
    logic              unused_addr_s;

    // Byte offsets are dropped; the TCM is word addressed.
    assign unused_addr_s = ^{ifu_cmd_addr[1:0], lsu_cmd_addr[1:0]};

    // Response-stage status: a new command may be taken when the stage is
    // empty or its current response is being consumed this very cycle.
    // rst_n is folded in so no RAM access can start while reset is asserted.
    always_comb begin
        rsp_busy_s = (state_r != ST_IDLE);
        if (owner_r == OWN_LSU) begin
            rsp_ready_s = lsu_rsp_ready;
        end else begin
            rsp_ready_s = ifu_rsp_ready;
        end
        rsp_hs_s     = rsp_busy_s && rsp_ready_s;
        can_accept_s = rst_n && (!rsp_busy_s || rsp_hs_s);
    end

    // Round-robin selection: pointer decides ties, a lone requester always wins.
    always_comb begin
        if (ifu_cmd_valid && lsu_cmd_valid) begin
            sel_lsu_s = prio_lsu_r;
        end else if (lsu_cmd_valid) begin
            sel_lsu_s = 1'b1;
        end else begin
            sel_lsu_s = 1'b0;
        end
        if (sel_lsu_s) begin
            grant_s = can_accept_s && lsu_cmd_valid;
        end else begin
            grant_s = can_accept_s && ifu_cmd_valid;
        end
        write_s = grant_s && sel_lsu_s && !lsu_cmd_read;
    end

    assign ifu_cmd_ready = can_accept_s && !sel_lsu_s;
    assign lsu_cmd_ready = can_accept_s && sel_lsu_s;

    // RAM command: issued in the grant cycle itself so data returns next cycle.
    always_comb begin
        ram_cs  = grant_s;
        ram_we  = write_s;
        ram_din = lsu_cmd_wdata;
        if (sel_lsu_s) begin
            ram_addr = lsu_cmd_addr[AW-1:2];
        end else begin
            ram_addr = ifu_cmd_addr[AW-1:2];
        end
        if (write_s) begin
            ram_wem = lsu_cmd_wmask;
        end else begin
            ram_wem = {MW{1'b0}};
        end
    end

    // Response data: live RAM output in the first response cycle, parked copy
    // while stalled; stores always answer with zero.
    always_comb begin
        case (state_r)
            ST_RSP: begin
                if (is_write_r) begin
                    rsp_data_s = {XLEN{1'b0}};
                end else begin
                    rsp_data_s = ram_dout;
                end
            end
            ST_HOLD: rsp_data_s = hold_r;
            default: rsp_data_s = {XLEN{1'b0}};
        endcase
    end

    assign ifu_rsp_valid = rsp_busy_s && (owner_r == OWN_IFU);
    assign lsu_rsp_valid = rsp_busy_s && (owner_r == OWN_LSU);
    assign ifu_rsp_rdata = rsp_data_s;
    assign lsu_rsp_rdata = rsp_data_s;

    // Response FSM, owner/kind of the outstanding access, hold register and
    // round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            owner_r    <= OWN_IFU;
            is_write_r <= 1'b0;
            hold_r     <= {XLEN{1'b0}};
            prio_lsu_r <= 1'b0;
        end else begin
            if (grant_s) begin
                prio_lsu_r <= !sel_lsu_s;
                owner_r    <= sel_lsu_s ? OWN_LSU : OWN_IFU;
                is_write_r <= write_s;
            end else begin
                prio_lsu_r <= prio_lsu_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r <= ST_RSP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RSP: begin
                    // A grant here implies the handshake, so it chains back-to-back.
                    if (grant_s) begin
                        state_r <= ST_RSP;
                    end else if (rsp_hs_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        hold_r  <= rsp_data_s;
                        state_r <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (grant_s) begin
                        state_r <= ST_RSP;
                    end else if (rsp_hs_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule : tcm_arbiter

// File: tb/tb_tcm_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_tcm_arbiter
// Self-checking bench: reset checks, a cycle table, directed multi-cycle
// scenarios and a randomized phase compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_tcm_arbiter;

    localparam int AW   = 16;
    localparam int XLEN = 32;
    localparam int MW   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ifu_cmd_valid, ifu_cmd_ready;
    logic [AW-1:0]   ifu_cmd_addr;
    logic            ifu_rsp_valid, ifu_rsp_ready;
    logic [XLEN-1:0] ifu_rsp_rdata;
    logic            lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
    logic [AW-1:0]   lsu_cmd_addr;
    logic [XLEN-1:0] lsu_cmd_wdata;
    logic [MW-1:0]   lsu_cmd_wmask;
    logic            lsu_rsp_valid, lsu_rsp_ready;
    logic [XLEN-1:0] lsu_rsp_rdata;
    logic            ram_cs, ram_we;
    logic [AW-3:0]   ram_addr;
    logic [MW-1:0]   ram_wem;
    logic [XLEN-1:0] ram_din, ram_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tcm_arbiter #(.AW(AW), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_addr(ifu_cmd_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
        .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Background contents of an unwritten RAM word
    function automatic logic [31:0] iw(input logic [7:0] i);
        return {i, 8'h3C, ~i, 8'hA5};
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // RAM model: 256 words (aliased on ram_addr[7:0]), 1-cycle read latency.
    // The output is scrambled in cycles without a read so stale data is visible.
    logic [31:0] ram_mem [0:255];
    logic        ram_vld [0:255];
    logic        ram_clear;

    function automatic logic [31:0] cur_word(input logic [7:0] a);
        return ram_vld[a] ? ram_mem[a] : iw(a);
    endfunction

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram_vld[i] <= 1'b0;
            ram_dout <= $urandom;
        end else if (ram_cs) begin
            if (ram_we) begin
                ram_mem[ram_addr[7:0]] <= merge_word(cur_word(ram_addr[7:0]), ram_din, ram_wem);
                ram_vld[ram_addr[7:0]] <= 1'b1;
                ram_dout <= $urandom;
            end else begin
                ram_dout <= cur_word(ram_addr[7:0]);
            end
        end else begin
            ram_dout <= $urandom;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_cmd_valid = 1'b0; ifu_cmd_addr = 16'h0010;
        lsu_cmd_valid = 1'b0; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0040;
        lsu_cmd_wdata = 32'hA5A5A5A5; lsu_cmd_wmask = 4'hF;
        ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ram_clear = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        ram_clear = 1'b0; rst_n = 1'b1;
    endtask

    typedef struct {
        logic ifu_v, lsu_v, lsu_rd, ifu_rr, lsu_rr;
        logic chk_rdy, e_ifu_rdy, e_lsu_rdy, e_cs, e_we;
        logic [13:0] e_addr;
        logic e_ifu_rv, e_lsu_rv, chk_rd;
        logic [31:0] e_rdata;
    } vec_t;
    vec_t tbl [10];

    // Transaction-level reference model state
    logic        busy_m, pend_lsu_m, fav_lsu_m;
    logic [31:0] pend_data_m;
    logic [31:0] mdl_mem [0:255];
    logic        hs_m, free_m, win_m, gnt_m, wr_m;
    logic [13:0] waddr_m;
    logic [31:0] exp36, w8, resp_m;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0; ram_clear = 1'b1;
        idle_inputs();
        ifu_cmd_valid = 1'b1; lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        chk("rst lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
        chk("rst ram_cs", 32'(ram_cs), 32'd0);
        chk("rst ram_we", 32'(ram_we), 32'd0);
        do_reset();

        // ---------------- cycle table ----------------
        tbl[0] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b0, 14'd4,  1'b0,1'b0,1'b0, 32'h0};
        tbl[1] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b1,1'b0, 14'd16, 1'b1,1'b0,1'b1, iw(8'd4)};
        tbl[2] = '{1'b1,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b0, 14'd4,  1'b0,1'b1,1'b1, iw(8'd16)};
        tbl[3] = '{1'b0,1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0, 14'd0,  1'b1,1'b0,1'b1, iw(8'd4)};
        tbl[4] = '{1'b1,1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0, 14'd0,  1'b1,1'b0,1'b1, iw(8'd4)};
        tbl[5] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b0, 14'd4,  1'b1,1'b0,1'b1, iw(8'd4)};
        tbl[6] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 14'd0,  1'b1,1'b0,1'b1, iw(8'd4)};
        tbl[7] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b1,1'b1, 14'd16, 1'b0,1'b0,1'b0, 32'h0};
        tbl[8] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 14'd0,  1'b0,1'b1,1'b1, 32'h0};
        tbl[9] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 14'd0,  1'b0,1'b0,1'b0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            ifu_cmd_valid = tbl[i].ifu_v; lsu_cmd_valid = tbl[i].lsu_v; lsu_cmd_read = tbl[i].lsu_rd;
            ifu_rsp_ready = tbl[i].ifu_rr; lsu_rsp_ready = tbl[i].lsu_rr;
            @(negedge clk);
            if (tbl[i].chk_rdy) begin
                chk($sformatf("tbl%0d ifu_cmd_ready", i), 32'(ifu_cmd_ready), 32'(tbl[i].e_ifu_rdy));
                chk($sformatf("tbl%0d lsu_cmd_ready", i), 32'(lsu_cmd_ready), 32'(tbl[i].e_lsu_rdy));
            end
            chk($sformatf("tbl%0d ram_cs", i), 32'(ram_cs), 32'(tbl[i].e_cs));
            chk($sformatf("tbl%0d ram_we", i), 32'(ram_we), 32'(tbl[i].e_we));
            if (tbl[i].e_cs) begin
                chk($sformatf("tbl%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
                chk($sformatf("tbl%0d ram_wem", i), 32'(ram_wem), tbl[i].e_we ? 32'hF : 32'h0);
            end
            chk($sformatf("tbl%0d ifu_rsp_valid", i), 32'(ifu_rsp_valid), 32'(tbl[i].e_ifu_rv));
            chk($sformatf("tbl%0d lsu_rsp_valid", i), 32'(lsu_rsp_valid), 32'(tbl[i].e_lsu_rv));
            if (tbl[i].chk_rd)
                chk($sformatf("tbl%0d rdata", i), tbl[i].e_ifu_rv ? ifu_rsp_rdata : lsu_rsp_rdata,
                    tbl[i].e_rdata);
            cyc();
        end
        idle_inputs();
        cyc();

        // ---------------- store 0xDEADBEEF to word 4, then IFU fetch ----------------
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0010;
        lsu_cmd_wdata = 32'hDEADBEEF; lsu_cmd_wmask = 4'hF;
        @(negedge clk);
        chk("s34 store we", 32'(ram_we), 32'd1);
        cyc();
        lsu_cmd_valid = 1'b0; ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0010;
        @(negedge clk);
        chk("s34 fetch cs", 32'(ram_cs), 32'd1);
        chk("s34 fetch addr", 32'(ram_addr), 32'd4);
        chk("s34 no same-cycle rsp", 32'(ifu_rsp_valid), 32'd0);
        chk("s34 store rsp rdata", lsu_rsp_rdata, 32'h0);
        cyc();
        ifu_cmd_valid = 1'b0;
        @(negedge clk);
        chk("s34 ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
        chk("s34 ifu rdata", ifu_rsp_rdata, 32'hDEADBEEF);
        cyc();

        // ---------------- partial store then fetch ----------------
        w8 = iw(8'd8);
        exp36 = {w8[31:16], 16'h5678};
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0020;
        lsu_cmd_wdata = 32'h12345678; lsu_cmd_wmask = 4'b0011;
        @(negedge clk);
        chk("s36 wem", 32'(ram_wem), 32'h3);
        cyc();
        lsu_cmd_valid = 1'b0; ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0020;
        @(negedge clk);
        chk("s36 store rsp valid", 32'(lsu_rsp_valid), 32'd1);
        chk("s36 store rsp rdata", lsu_rsp_rdata, 32'h0);
        cyc();
        ifu_cmd_valid = 1'b0;
        @(negedge clk);
        chk("s36 merged rdata", ifu_rsp_rdata, exp36);
        cyc();

        // ---------------- LSU load stalled three cycles ----------------
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0020;
        @(negedge clk);
        chk("s37 lsu grant", 32'(lsu_cmd_ready), 32'd1);
        cyc();
        lsu_cmd_valid = 1'b0; lsu_rsp_ready = 1'b0; ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("s37 stall%0d lsu_rsp_valid", k), 32'(lsu_rsp_valid), 32'd1);
            chk($sformatf("s37 stall%0d rdata", k), lsu_rsp_rdata, exp36);
            chk($sformatf("s37 stall%0d ifu_cmd_ready", k), 32'(ifu_cmd_ready), 32'd0);
            chk($sformatf("s37 stall%0d ram_cs", k), 32'(ram_cs), 32'd0);
            cyc();
        end
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        chk("s37 hs lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
        chk("s37 hs rdata", lsu_rsp_rdata, exp36);
        chk("s37 hs ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd1);
        chk("s37 hs ram_cs", 32'(ram_cs), 32'd1);
        cyc();
        ifu_cmd_valid = 1'b0;
        @(negedge clk);
        chk("s37 ifu rdata", ifu_rsp_rdata, 32'hDEADBEEF);
        chk("s37 lsu_rsp_valid low", 32'(lsu_rsp_valid), 32'd0);
        cyc();

        // ---------------- reset while a response is pending ----------------
        ifu_cmd_valid = 1'b1;
        cyc();
        ifu_cmd_valid = 1'b0;
        #1;
        chk("s38 pre-reset rsp", 32'(ifu_rsp_valid), 32'd1);
        rst_n = 1'b0;
        ifu_cmd_valid = 1'b1; lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1;
        #1;
        chk("s38 ifu_rsp_valid drop", 32'(ifu_rsp_valid), 32'd0);
        chk("s38 lsu_rsp_valid drop", 32'(lsu_rsp_valid), 32'd0);
        chk("s38 ram_cs in reset", 32'(ram_cs), 32'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("s38 first ifu_cmd_ready", 32'(ifu_cmd_ready), 32'd1);
        chk("s38 first lsu_cmd_ready", 32'(lsu_cmd_ready), 32'd0);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk("s38 ifu rdata", ifu_rsp_rdata, 32'hDEADBEEF);
        cyc();

        // ---------------- randomized phase vs. transaction model ----------------
        do_reset();
        for (int i = 0; i < 256; i++) mdl_mem[i] = iw(8'(i));
        busy_m = 1'b0; pend_lsu_m = 1'b0; fav_lsu_m = 1'b0; pend_data_m = 32'h0;
        for (int n = 0; n < 800; n++) begin
            ifu_cmd_valid = ($urandom_range(0, 3) != 0);
            lsu_cmd_valid = ($urandom_range(0, 3) != 0);
            lsu_cmd_read  = 1'($urandom_range(0, 1));
            ifu_cmd_addr  = 16'($urandom);
            lsu_cmd_addr  = 16'($urandom);
            lsu_cmd_wdata = $urandom;
            lsu_cmd_wmask = 4'($urandom);
            ifu_rsp_ready = ($urandom_range(0, 3) != 0);
            lsu_rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs_m   = busy_m && (pend_lsu_m ? lsu_rsp_ready : ifu_rsp_ready);
            free_m = !busy_m || hs_m;
            win_m  = (ifu_cmd_valid && lsu_cmd_valid) ? fav_lsu_m : lsu_cmd_valid;
            gnt_m  = free_m && (ifu_cmd_valid || lsu_cmd_valid);
            wr_m   = gnt_m && win_m && !lsu_cmd_read;
            waddr_m = win_m ? lsu_cmd_addr[15:2] : ifu_cmd_addr[15:2];
            if (ifu_cmd_valid || lsu_cmd_valid) begin
                chk("rnd ifu_cmd_ready", 32'(ifu_cmd_ready), 32'(free_m && !win_m));
                chk("rnd lsu_cmd_ready", 32'(lsu_cmd_ready), 32'(free_m && win_m));
            end
            chk("rnd ram_cs", 32'(ram_cs), 32'(gnt_m));
            chk("rnd ram_we", 32'(ram_we), 32'(wr_m));
            if (gnt_m) begin
                chk("rnd ram_addr", 32'(ram_addr), 32'(waddr_m));
                chk("rnd ram_wem", 32'(ram_wem), wr_m ? 32'(lsu_cmd_wmask) : 32'h0);
                if (wr_m) chk("rnd ram_din", ram_din, lsu_cmd_wdata);
            end
            chk("rnd ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(busy_m && !pend_lsu_m));
            chk("rnd lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(busy_m && pend_lsu_m));
            if (busy_m) begin
                resp_m = pend_lsu_m ? lsu_rsp_rdata : ifu_rsp_rdata;
                chk("rnd rsp rdata", resp_m, pend_data_m);
            end
            if (gnt_m) begin
                busy_m = 1'b1; pend_lsu_m = win_m; fav_lsu_m = !win_m;
                if (wr_m) begin
                    pend_data_m = 32'h0;
                    mdl_mem[waddr_m[7:0]] = merge_word(mdl_mem[waddr_m[7:0]], lsu_cmd_wdata, lsu_cmd_wmask);
                end else begin
                    pend_data_m = mdl_mem[waddr_m[7:0]];
                end
            end else if (hs_m) begin
                busy_m = 1'b0;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tcm_arbiter

// File: doc/tcm_arbiter.md
TCM_ARBITER -- requirements
Module: tcm_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16: byte-address width of the shared TCM.
REQ-002 SHALL have parameter XLEN, default 32: data width; the mask width is XLEN/8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have IFU command ports ifu_cmd_valid in 1, ifu_cmd_ready out 1, ifu_cmd_addr in AW: read-only fetch requests.
REQ-006 SHALL have IFU response ports ifu_rsp_valid out 1, ifu_rsp_ready in 1, ifu_rsp_rdata out XLEN.
REQ-007 SHALL have LSU command ports lsu_cmd_valid in 1, lsu_cmd_ready out 1, lsu_cmd_read in 1, lsu_cmd_addr in AW, lsu_cmd_wdata in XLEN, lsu_cmd_wmask in XLEN/8.
REQ-008 SHALL have LSU response ports lsu_rsp_valid out 1, lsu_rsp_ready in 1, lsu_rsp_rdata out XLEN.
REQ-009 SHALL have RAM ports ram_cs out 1, ram_we out 1, ram_addr out AW-2 (word address), ram_wem out XLEN/8, ram_din out XLEN, ram_dout in XLEN; the RAM has 1-cycle read latency.

Function
REQ-010 SHALL grant at most one command per cycle; a grant is cmd_valid && cmd_ready for the selected requester.
REQ-011 SHALL arbitrate round-robin when both requesters are valid; the requester not granted last wins; the pointer updates only on a grant.
REQ-012 SHALL grant a lone valid requester regardless of the pointer.
REQ-013 SHALL assert cmd_ready only for the selected requester and only when can_accept = (state==IDLE) || (response handshake completes this cycle).
REQ-014 SHALL drive ram_cs=1 on a grant, with ram_addr=addr[AW-1:2], ram_we=LSU && !lsu_cmd_read, ram_wem=wmask for writes and 0 for reads, and ram_din=wdata.
REQ-015 SHALL drive ram_cs=0 and ram_we=0 in cycles without a grant.
REQ-016 SHALL run an FSM with states IDLE, RSP and HOLD.
REQ-017 On a grant, the FSM SHALL go to RSP and register owner (IFU/LSU) and is_write.
REQ-018 In RSP, the owner's rsp_valid SHALL be 1 and rdata SHALL equal ram_dout (0 when is_write).
REQ-019 In RSP with the handshake and no new grant, the FSM SHALL go to IDLE.
REQ-020 In RSP with the handshake and a new grant, the FSM SHALL stay in RSP with the new owner, giving 1 access per cycle back-to-back.
REQ-021 In RSP without the handshake, the FSM SHALL capture rdata into hold_q and go to HOLD.
REQ-022 In HOLD, rsp_valid SHALL be 1 and rdata SHALL be hold_q, stable until the handshake; the handshake returns the FSM to IDLE, or to RSP if a grant occurs in the same cycle.
REQ-023 SHALL keep the non-owner's rsp_valid at 0 always.
REQ-024 SHALL return a response for stores with rdata=0.
REQ-025 Read latency SHALL be exactly 1 cycle from grant to rsp_valid; the response and its command SHALL never share a cycle.
REQ-026 SHALL keep at most one response outstanding; a requester never receives an out-of-order response.
REQ-027 Simultaneous IFU and LSU valid while the response stage is stalled: neither SHALL be granted; the pointer is unchanged.
REQ-028 SHALL leave cmd_valid deassertion before grant without effect; no request is latched before the grant.

Reset
REQ-029 On rst_n=0, asynchronously, the FSM SHALL enter IDLE, the pointer SHALL favour IFU, and owner, is_write and hold_q SHALL clear to 0.
REQ-030 During reset, outputs SHALL be: ifu/lsu_rsp_valid=0, ram_cs=0, ram_we=0.
REQ-031 Reset mid-transaction SHALL drop the pending response; the first grant after release goes to IFU when both are valid.

Structure
REQ-032 SHALL take XLEN and ITCM/DTCM address-width constants from the shared defines file; FSM state encodings and owner encodings SHALL be local.
REQ-033 SHALL be a single module with no sub-module; RR selection is inline logic.

Verification
REQ-034 Scenario: IFU read addr 0x0010 alone, RAM word 4 = 0xDEADBEEF -> ram_cs cycle N, ifu_rsp_valid with 0xDEADBEEF cycle N+1.
REQ-035 Scenario: both valid every cycle, rsp_ready=1 -> grants alternate IFU, LSU, IFU, LSU; one ram_cs per cycle; no bubbles.
REQ-036 Scenario: LSU write 0x0020, wdata 0x12345678, wmask 4'b0011, then IFU read 0x0020 -> IFU returns low half 0x5678 merged with the prior upper half; LSU store response rdata=0.
REQ-037 Scenario: LSU read, lsu_rsp_ready=0 for 3 cycles -> lsu_rsp_valid held 4 cycles with constant data; ifu_cmd_ready=0 throughout; IFU granted in the handshake cycle.
REQ-038 Scenario: rst_n pulsed low while in RSP -> both rsp_valid drop immediately; after release, both valid -> IFU granted first.
